gate_sweep_checker: RTL
=======================

Name: gate_sweep_checker

Overview:
Synthesizable self-test engine for combinational gates with N_IN inputs. It drives every input vector 0 .. 2^N_IN-1 in order onto an external gate under test. Each vector is held for a programmable settle time. The engine then samples the gate output and compares it against an internal reference model of the selected function. It counts mismatches and records the first failing vector. It replaces hand-written per-gate stimulus benches and can also run on-board as a built-in self-test.

Parameters:
N_IN, 2, number of gate inputs; legal 1..8
HOLD_CYCLES, 1, settle cycles per vector before sampling; legal >=1
CNT_W, N_IN+1, width of the error counter; must hold up to 2^N_IN

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a sweep when in IDLE or DONE
op_sel  input  3  expected function; latched at start
vec  output  N_IN  stimulus to the gate under test
dut_o  input  1  output of the gate under test
busy  output  1  high while a sweep is in progress
done  output  1  high in DONE until the next start or reset
pass  output  1  done AND err_count==0
err_count  output  CNT_W  number of mismatching vectors
first_fail_vec  output  N_IN  first vector that mismatched
first_fail_valid  output  1  first_fail_vec holds a valid vector

Behaviour:
- Reset values (asynchronous, rst=1): state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, hold counter=0, latched op=000. Reset mid-sweep aborts the sweep immediately. No partial results survive.
- op_sel encoding: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 BUF, 111 NOT.
  - AND through XNOR reduce over all N_IN bits of vec.
  - BUF and NOT use vec[0] only.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE / DONE, start=1 at an edge:
  - go to SETTLE; vec=0; err_count=0; first_fail_valid=0; first_fail_vec=0; latch op_sel; hold counter=0; busy=1; done=0.
- SETTLE: vec is stable. The hold counter increments each cycle. On the edge where the counter reaches HOLD_CYCLES-1, go to SAMPLE.
- SAMPLE (exactly one cycle):
  - Compare dut_o with ref(vec, op) at the ending edge.
  - On mismatch, increment err_count (saturating at the all-ones value). If first_fail_valid=0, capture first_fail_vec=vec and set first_fail_valid=1.
  - If vec is all ones: go to DONE, busy=0, done=1.
  - Otherwise: vec=vec+1, hold counter=0, return to SETTLE.
- Timing: each vector occupies HOLD_CYCLES+1 cycles. done rises 2^N_IN*(HOLD_CYCLES+1) cycles after the edge that accepted start.
- start while busy=1 is ignored. No restart, no effect on counters.
- start in DONE restarts the sweep. done drops on the accepting edge.
- op_sel changes mid-sweep have no effect (latched value used).
- vec holds its last value (all ones) in DONE. It holds 0 in IDLE.
- pass is registered and valid only in DONE. It is 0 otherwise.
- dut_o is sampled synchronously. The gate path must settle within HOLD_CYCLES cycles. No internal synchroniser.

Decomposition:
- Shared package gate_pkg:
  - op encoding localparams (OP_AND..OP_NOT);
  - state encoding localparams (ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE).
- Sub-module gate_ref_model: purely combinational, parameter N_IN.
  - Inputs: vec, op. Output: expected.
  - Reused by other gate benches.
- Top gate_sweep_checker holds the FSM, hold counter, vector counter and result registers.

Test Plan:
1. N_IN=2, HOLD=1, op=NOR, dut_o=~|vec -> done exactly 8 cycles after start; err_count=0, pass=1, first_fail_valid=0, vec=2'b11 in DONE.
2. N_IN=2, op=NOR, dut_o=|vec (OR wired in) -> err_count=4, first_fail_vec=0, first_fail_valid=1, pass=0.
3. N_IN=2, op=XOR, dut_o=XOR except forced 0 at vec=2'b10 -> err_count=1, first_fail_vec=2'b10, pass=0.
4. N_IN=4, HOLD=3, op=AND, correct DUT -> done 64 cycles after start; pass=1. Also toggle op_sel mid-sweep -> no effect on the result.
5. Assert rst asynchronously while in SETTLE at vec=2 -> all outputs return to reset values immediately. A new start gives a clean sweep with err_count starting at 0.
6. Pulse start while busy -> ignored, completion time unchanged. Then pulse start in DONE -> done=0 next cycle, counters cleared, full sweep repeats.

Source files
------------

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared op and state encodings for gate sweep blocks
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_BUF  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational reference output of the selected gate function
module gate_ref_model
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] vec,
  input  logic [2:0]      op,
  output logic            expected
);

  // BUF and NOT look at bit 0 only; the rest reduce over the whole vector
  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = &vec;
      OP_OR:   expected = |vec;
      OP_NAND: expected = ~&vec;
      OP_NOR:  expected = ~|vec;
      OP_XOR:  expected = ^vec;
      OP_XNOR: expected = ~^vec;
      OP_BUF:  expected = vec[0];
      OP_NOT:  expected = ~vec[0];
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive input sweep of an external gate against the reference model
module gate_sweep_checker
  import gate_pkg::*;
#(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_sel,
  output logic [N_IN-1:0]  vec,
  input  logic             dut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t           state, state_n;
  logic [HW-1:0]    hold_q, hold_n;
  logic [2:0]       op_q, op_n;
  logic [N_IN-1:0]  vec_n, ff_vec_n;
  logic [CNT_W-1:0] err_n;
  logic             ff_valid_n, busy_n, done_n, pass_n;
  logic             expected, mismatch;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .vec      (vec),
    .op       (op_q),
    .expected (expected)
  );

  assign mismatch = (dut_o != expected);

  always_comb begin
    state_n    = state;
    hold_n     = hold_q;
    op_n       = op_q;
    vec_n      = vec;
    err_n      = err_count;
    ff_vec_n   = first_fail_vec;
    ff_valid_n = first_fail_valid;
    busy_n     = busy;
    done_n     = done;
    pass_n     = pass;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n    = ST_SETTLE;
          hold_n     = '0;
          op_n       = op_sel;
          vec_n      = '0;
          err_n      = '0;
          ff_vec_n   = '0;
          ff_valid_n = 1'b0;
          busy_n     = 1'b1;
          done_n     = 1'b0;
          pass_n     = 1'b0;
        end
      end
      ST_SETTLE: begin
        hold_n = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) state_n = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_count != '1) err_n = err_count + 1'b1;
          if (!first_fail_valid) begin
            ff_vec_n   = vec;
            ff_valid_n = 1'b1;
          end
        end
        // vec stays at all ones in DONE so the last stimulus remains visible
        if (vec == '1) begin
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          state_n = ST_SETTLE;
          vec_n   = vec + 1'b1;
          hold_n  = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        pass_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      hold_q           <= '0;
      op_q             <= 3'b000;
      vec              <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      state            <= state_n;
      hold_q           <= hold_n;
      op_q             <= op_n;
      vec              <= vec_n;
      err_count        <= err_n;
      first_fail_vec   <= ff_vec_n;
      first_fail_valid <= ff_valid_n;
      busy             <= busy_n;
      done             <= done_n;
      pass             <= pass_n;
    end
  end

endmodule
